// File: rtl/id_ex_stage_if.sv
// Decode/forwarding/exec bundle around the ID/EX pipeline register.
// master drives the decode-side signals; slave is the id_ex_stage register.
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 16
);
  logic               id_valid;
  logic               id_ready;
  logic [XLEN-1:0]    id_pc;
  logic [RADDR_W-1:0] id_rs1_src;
  logic [RADDR_W-1:0] id_rs2_src;
  logic [RADDR_W-1:0] id_rd_src;
  logic               id_rd_we;
  logic               id_is_load;
  logic [XLEN-1:0]    id_rs1_val;
  logic [XLEN-1:0]    id_rs2_val;
  logic [XLEN-1:0]    id_imm;
  logic [CTRL_W-1:0]  id_ctrl;
  logic               is_fwd_rs1;
  logic               is_fwd_rs2;
  logic [XLEN-1:0]    fwd_val;
  logic               ex_flush;
  logic               ex_ready;
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    ex_imm;
  logic [XLEN-1:0]    ex_rs1_val;
  logic [XLEN-1:0]    ex_rs2_val;
  logic [RADDR_W-1:0] ex_rd_src;
  logic               ex_rd_we;
  logic               ex_is_load;
  logic [CTRL_W-1:0]  ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs1_src, id_rs2_src, id_rd_src, id_rd_we, id_is_load,
           id_rs1_val, id_rs2_val, id_imm, id_ctrl, is_fwd_rs1, is_fwd_rs2, fwd_val,
           ex_flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rd_src,
           ex_rd_we, ex_is_load, ex_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_src, id_rs2_src, id_rd_src, id_rd_we, id_is_load,
           id_rs1_val, id_rs2_val, id_imm, id_ctrl, is_fwd_rs1, is_fwd_rs2, fwd_val,
           ex_flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rd_src,
           ex_rd_we, ex_is_load, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// rv32i ID/EX pipeline register: operand bypass capture, one-bubble load-use stall,
// exec backpressure and flush. Optional FWD_X0_GUARD_EN forces x0 operands to zero.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  typedef enum logic {RUN, LU_BUBBLE} state_t;

  state_t             state, state_nx;
  logic               adv, hz, do_load, do_hold;
  logic [XLEN-1:0]    op1, op2;

  logic               ex_valid_q;
  logic [XLEN-1:0]    ex_pc_q, ex_imm_q, ex_rs1_q, ex_rs2_q;
  logic [RADDR_W-1:0] ex_rd_q;
  logic               ex_we_q, ex_ld_q;
  logic [CTRL_W-1:0]  ex_ctrl_q;

  always_comb begin
`ifdef FWD_X0_GUARD_EN
    op1 = (bus.id_rs1_src == '0) ? '0 : (bus.is_fwd_rs1 ? bus.fwd_val : bus.id_rs1_val);
    op2 = (bus.id_rs2_src == '0) ? '0 : (bus.is_fwd_rs2 ? bus.fwd_val : bus.id_rs2_val);
`else
    op1 = bus.is_fwd_rs1 ? bus.fwd_val : bus.id_rs1_val;
    op2 = bus.is_fwd_rs2 ? bus.fwd_val : bus.id_rs2_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // LU_BUBBLE always leaves after one cycle: ex_valid is 0 there, so adv holds.
  always_comb begin
    state_nx = RUN;
    case (state)
      RUN:       if (!bus.ex_flush && adv && hz) state_nx = LU_BUBBLE;
      LU_BUBBLE: state_nx = RUN;
      default:   state_nx = RUN;
    endcase
  end

  always_comb begin
    adv = !ex_valid_q || bus.ex_ready;
    hz  = (state == RUN) && ex_valid_q && ex_ld_q && ex_we_q && (ex_rd_q != '0) &&
          bus.id_valid && ((ex_rd_q == bus.id_rs1_src) || (ex_rd_q == bus.id_rs2_src));
    bus.id_ready = bus.ex_flush || (adv && !hz);
    do_hold      = !bus.ex_flush && !adv;
    do_load      = !bus.ex_flush && adv && !hz && bus.id_valid;
  end

  // Flush, hazard bubble and idle decode all collapse to "not holding, not loading".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (!do_hold) begin
      ex_valid_q <= do_load;
      if (do_load) begin
        ex_pc_q   <= bus.id_pc;
        ex_imm_q  <= bus.id_imm;
        ex_rs1_q  <= op1;
        ex_rs2_q  <= op2;
        ex_rd_q   <= bus.id_rd_src;
        ex_we_q   <= bus.id_rd_we;
        ex_ld_q   <= bus.id_is_load;
        ex_ctrl_q <= bus.id_ctrl;
      end
    end
  end

  always_comb begin
    bus.ex_valid   = ex_valid_q;
    bus.ex_pc      = ex_pc_q;
    bus.ex_imm     = ex_imm_q;
    bus.ex_rs1_val = ex_rs1_q;
    bus.ex_rs2_val = ex_rs2_q;
    bus.ex_rd_src  = ex_rd_q;
    bus.ex_rd_we   = ex_we_q;
    bus.ex_is_load = ex_ld_q;
    bus.ex_ctrl    = ex_ctrl_q;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected exec contents,
// a negedge monitor pops one entry per exec handshake; timing checks run inline.
module tb_id_ex_stage;
  logic clk, rst;
  int   n_vec, n_err;

  typedef struct {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        we, ld;
    logic [15:0] ctrl;
  } exp_t;

  exp_t exp_q[$];

  id_ex_stage_if #(.XLEN(32), .RADDR_W(5), .CTRL_W(16)) bus ();

  id_ex_stage #(.XLEN(32), .RADDR_W(5), .CTRL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid   = 1'b0;
    bus.is_fwd_rs1 = 1'b0;
    bus.is_fwd_rs2 = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                       input logic f1, input logic f2, input logic [31:0] fv);
    bus.id_valid   = 1'b1;
    bus.id_pc      = pc;
    bus.id_rs1_src = rs1;
    bus.id_rs2_src = rs2;
    bus.id_rd_src  = rd;
    bus.id_rd_we   = we;
    bus.id_is_load = ld;
    bus.id_rs1_val = v1;
    bus.id_rs2_val = v2;
    bus.id_imm     = imm;
    bus.id_ctrl    = pc[15:0] ^ 16'hA5A5;
    bus.is_fwd_rs1 = f1;
    bus.is_fwd_rs2 = f2;
    bus.fwd_val    = fv;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                      input logic ld, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [31:0] imm);
    exp_t e;
    e.pc = pc; e.rd = rd; e.we = we; e.ld = ld;
    e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.ctrl = pc[15:0] ^ 16'hA5A5;
    exp_q.push_back(e);
  endtask

  // One entry consumed per cycle in which exec takes the register contents.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got pc 0x%0h expected no instruction", bus.ex_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.ex_pc !== e.pc || bus.ex_rs1_val !== e.op1 || bus.ex_rs2_val !== e.op2 ||
              bus.ex_imm !== e.imm || bus.ex_rd_src !== e.rd || bus.ex_rd_we !== e.we ||
              bus.ex_is_load !== e.ld || bus.ex_ctrl !== e.ctrl) begin
            n_err++;
            $display("FAIL ex_bundle: got pc=%h op1=%h op2=%h imm=%h rd=%0d we=%b ld=%b ctrl=%h expected pc=%h op1=%h op2=%h imm=%h rd=%0d we=%b ld=%b ctrl=%h",
                     bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_rd_src,
                     bus.ex_rd_we, bus.ex_is_load, bus.ex_ctrl,
                     e.pc, e.op1, e.op2, e.imm, e.rd, e.we, e.ld, e.ctrl);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] x0_op1, x0_op2;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.ex_flush = 1'b0;
    bus.ex_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_pc", bus.ex_pc, 0);
    rst = 1'b0;
    step();

    // Bypass on rs1 only
    drive(32'h10, 1, 2, 3, 1, 0, 32'h11, 32'h22, 32'h7, 1, 0, 32'hDEADBEEF);
    push(32'h10, 3, 1, 0, 32'hDEADBEEF, 32'h22, 32'h7);
    at_neg(); chk("byp_id_ready", bus.id_ready, 1);
    step(); idle();
    at_neg();
    chk("byp_ex_valid", bus.ex_valid, 1);
    chk("byp_rs1", bus.ex_rs1_val, 32'hDEADBEEF);
    chk("byp_rs2", bus.ex_rs2_val, 32'h22);
    step();

    // Load x5 then add x6,x5,x7: one bubble
    drive(32'h20, 2, 3, 5, 1, 1, 32'h1000, 32'h0, 32'h4, 0, 0, 0);
    push(32'h20, 5, 1, 1, 32'h1000, 32'h0, 32'h4);
    at_neg(); step();
    drive(32'h24, 5, 7, 6, 1, 0, 32'h55, 32'h77, 32'h0, 0, 0, 0);
    at_neg();
    chk("lu_stall_ready", bus.id_ready, 0);
    chk("lu_load_valid", bus.ex_valid, 1);
    step();
    at_neg();
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_ready", bus.id_ready, 1);
    push(32'h24, 6, 1, 0, 32'h55, 32'h77, 32'h0);
    step(); idle();
    at_neg();
    chk("lu_add_valid", bus.ex_valid, 1);
    chk("lu_add_pc", bus.ex_pc, 32'h24);
    step();

    // Dependence on both rs1 and rs2: still a single stall cycle
    drive(32'h30, 2, 3, 8, 1, 1, 32'h2000, 32'h0, 32'h0, 0, 0, 0);
    push(32'h30, 8, 1, 1, 32'h2000, 32'h0, 32'h0);
    at_neg(); step();
    drive(32'h34, 8, 8, 9, 1, 0, 32'h66, 32'h88, 32'h0, 0, 0, 0);
    at_neg(); chk("both_stall_ready", bus.id_ready, 0);
    step();
    at_neg(); chk("both_bubble_ready", bus.id_ready, 1);
    push(32'h34, 9, 1, 0, 32'h66, 32'h88, 32'h0);
    step(); idle();
    at_neg(); chk("both_pc", bus.ex_pc, 32'h34);
    step();

    // Load to x0 never stalls
    drive(32'h40, 2, 3, 0, 1, 1, 32'h3000, 32'h0, 32'h0, 0, 0, 0);
    push(32'h40, 0, 1, 1, 32'h3000, 32'h0, 32'h0);
    at_neg(); step();
    drive(32'h44, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    at_neg(); chk("x0_load_ready", bus.id_ready, 1);
    push(32'h44, 1, 1, 0, 32'h0, 32'h0, 32'h0);
    step(); idle();
    at_neg(); chk("x0_load_next_pc", bus.ex_pc, 32'h44);
    step();

    // Backpressure: exec stalls three cycles holding pc 0x100
    drive(32'h100, 1, 2, 3, 1, 0, 32'hA, 32'hB, 32'h0, 0, 0, 0);
    push(32'h100, 3, 1, 0, 32'hA, 32'hB, 32'h0);
    at_neg(); step();
    bus.ex_ready = 1'b0;
    drive(32'h104, 1, 2, 4, 1, 0, 32'hC, 32'hD, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_hold_pc", bus.ex_pc, 32'h100);
      chk("bp_hold_rs1", bus.ex_rs1_val, 32'hA);
      chk("bp_id_ready", bus.id_ready, 0);
      step();
    end
    bus.ex_ready = 1'b1;
    at_neg(); chk("bp_resume_ready", bus.id_ready, 1);
    push(32'h104, 4, 1, 0, 32'hC, 32'hD, 32'h0);
    step(); idle();
    at_neg(); chk("bp_next_pc", bus.ex_pc, 32'h104);
    step();

    // Flush in the same cycle as a load-use hazard
    drive(32'h50, 2, 3, 9, 1, 1, 32'h4000, 32'h0, 32'h0, 0, 0, 0);
    push(32'h50, 9, 1, 1, 32'h4000, 32'h0, 32'h0);
    at_neg(); step();
    drive(32'h54, 9, 1, 10, 1, 0, 32'h1, 32'h2, 32'h0, 0, 0, 0);
    bus.ex_flush = 1'b1;
    at_neg(); chk("flush_id_ready", bus.id_ready, 1);
    step();
    bus.ex_flush = 1'b0;
    drive(32'h58, 1, 2, 11, 1, 0, 32'h5, 32'h6, 32'h0, 0, 0, 0);
    at_neg();
    chk("flush_ex_valid", bus.ex_valid, 0);
    chk("flush_next_ready", bus.id_ready, 1);
    push(32'h58, 11, 1, 0, 32'h5, 32'h6, 32'h0);
    step(); idle();
    at_neg(); chk("flush_next_pc", bus.ex_pc, 32'h58);
    step();

    // x0 source operands with forwarding asserted
`ifdef FWD_X0_GUARD_EN
    x0_op1 = 32'h0;
    x0_op2 = 32'h0;
`else
    x0_op1 = 32'h44;
    x0_op2 = 32'h5;
`endif
    drive(32'h60, 0, 0, 12, 1, 0, 32'h44, 32'h33, 32'h0, 0, 1, 32'h5);
    push(32'h60, 12, 1, 0, x0_op1, x0_op2, 32'h0);
    at_neg(); step(); idle();
    at_neg(); chk("x0_rs2_val", bus.ex_rs2_val, x0_op2);
    step();

    // Asynchronous reset mid-cycle while holding a valid instruction
    drive(32'h200, 1, 2, 3, 1, 0, 32'h1, 32'h2, 32'h0, 0, 0, 0);
    push(32'h200, 3, 1, 0, 32'h1, 32'h2, 32'h0);
    at_neg(); step();
    bus.ex_ready = 1'b0;
    idle();
    chk("pre_rst_valid", bus.ex_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 0);
    chk("arst_ex_pc", bus.ex_pc, 0);
    chk("arst_ex_rs1", bus.ex_rs1_val, 0);
    chk("arst_ex_ctrl", bus.ex_ctrl, 0);
    chk("arst_ex_rd_we", bus.ex_rd_we, 0);
    exp_q.delete();
    at_neg();
    rst = 1'b0;
    bus.ex_ready = 1'b1;
    step();
    at_neg();
    chk("post_rst_ready", bus.id_ready, 1);
    chk("post_rst_valid", bus.ex_valid, 0);

    repeat (3) step();
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the rv32i core, sitting between decode and exec.
- Consumes the forwarding unit's bypass flags and value, and latches bypassed operands for exec.
- Detects load-use hazards and inserts exactly one bubble per hazard.
- Handles exec backpressure and branch flush with a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register-address width.
- CTRL_W, 16, width of the opaque decode control bundle.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_src  in  RADDR_W  rs1 index
- id_rs2_src  in  RADDR_W  rs2 index
- id_rd_src  in  RADDR_W  rd index
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_rs1_val  in  XLEN  register-file rs1 read
- id_rs2_val  in  XLEN  register-file rs2 read
- id_imm  in  XLEN  immediate
- id_ctrl  in  CTRL_W  control bundle
- is_fwd_rs1  in  1  forwarding unit: bypass rs1
- is_fwd_rs2  in  1  forwarding unit: bypass rs2
- fwd_val  in  XLEN  forwarding unit bypass value
- ex_flush  in  1  exec redirect (taken branch/jump)
- ex_ready  in  1  exec accepts the current contents
- ex_valid  out  1  register holds a valid instruction
- ex_pc, ex_imm  out  XLEN  latched copies
- ex_rs1_val, ex_rs2_val  out  XLEN  latched bypassed operands
- ex_rd_src  out  RADDR_W  latched rd index
- ex_rd_we, ex_is_load  out  1  latched flags
- ex_ctrl  out  CTRL_W  latched control bundle

Behaviour:
- Reset: one clock, asynchronous active-high reset. All ex_* outputs reset to 0 and the state resets to RUN.
- Advance condition: adv = !ex_valid || ex_ready.
- Operand mux (combinational, captured on accept):
  - op1 = is_fwd_rs1 ? fwd_val : id_rs1_val
  - op2 = is_fwd_rs2 ? fwd_val : id_rs2_val
- Hazard: hz = state==RUN && ex_valid && ex_is_load && ex_rd_we && ex_rd_src!=0 && id_valid && (ex_rd_src==id_rs1_src || ex_rd_src==id_rs2_src).
- id_ready = ex_flush || (adv && !hz).
- State RUN, per cycle, in priority order:
  1. ex_flush=1: ex_valid<=0; decode instruction dropped; state stays RUN. Flush beats hazard and stall.
  2. !adv (ex_valid=1 and ex_ready=0): hold every ex_* register.
  3. adv && hz: ex_valid<=0 (bubble, other fields don't-care); state<=LU_BUBBLE.
  4. adv && id_valid: latch all id_* fields and op1/op2; ex_valid<=1.
  5. adv && !id_valid: ex_valid<=0.
- State LU_BUBBLE:
  - Lasts exactly one cycle; hazard check is suppressed.
  - Applies the same priority rules 1, 2, 4, 5, then returns to RUN. Flush also returns to RUN.
- Latency: one cycle from decode accept to ex_valid.
- Throughput: 1 instruction/cycle with no hazard; 2 cycles for a dependent instruction after a load.
- Hazard match on both rs1 and rs2: still one bubble only.
- rd=x0 load: never stalls.
- Reset asserted mid-stall or mid-bubble: immediately clears to the reset state; any in-flight instruction is lost.

Optional Feature:
- Macro: FWD_X0_GUARD_EN.
- Defined: if id_rsN_src==0, ignore is_fwd_rsN and latch operand 0, regardless of the register-file value.
- Undefined: forwarding flags are used unconditionally, as given by the forwarding unit.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all ex_* read 0 immediately, before the next clk edge; id_ready=1 after release.
- Bypass: id_rs1_val=0x11, fwd_val=0xDEADBEEF, is_fwd_rs1=1, is_fwd_rs2=0, id_rs2_val=0x22 -> next cycle ex_rs1_val=0xDEADBEEF, ex_rs2_val=0x22, ex_valid=1.
- Load-use: exec holds a load to x5, decode `add x6,x5,x7` -> id_ready=0 for one cycle, one ex_valid=0 bubble, then the add latched; no second bubble.
- Backpressure: ex_ready=0 for 3 cycles with ex_pc=0x100 -> ex_* stable and id_ready=0 for 3 cycles; accept resumes when ex_ready=1.
- Flush vs hazard: ex_flush=1 in the same cycle as hz=1 -> id_ready=1, ex_valid=0 next cycle, state RUN.
- X0 guard: id_rs2_src=0, is_fwd_rs2=1, fwd_val=0x5 -> ex_rs2_val=0 with FWD_X0_GUARD_EN defined; 0x5 without it.
